spi_cmd_sequencer: RTL and testbench

SPI_CMD_SEQUENCER -- requirements
Module: spi_cmd_sequencer

---
 rtl/spi_cmd_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_spi_cmd_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// spi_cmd_sequencer
//
// Purpose: turns the byte stream of an SPI slave into register accesses.
// The first byte of each frame is a command: bit7 = write (1) or read (0),
// bits 6:AW are reserved and must be zero, and bits AW-1:0 give the start
// address. In a write frame each following byte is written to the register
// file. In a read frame the addressed register is presented on tx_byte for
// the next transfer. A command with a reserved bit set discards the rest of
// the frame and bumps a saturating error counter.
//
// Optional feature (compile-time macro SPI_SEQ_BURST_EN):
//   defined   -> the address auto-increments (mod NUM_REGS) after every data
//                byte, so a frame can stream through the register file.
//   undefined -> the address is fixed; the first data byte of a read or
//                write frame moves the sequencer to DISCARD (no error).
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   asynchronous active-high reset
//   frame_active in   slave-select asserted (already synchronised to clk)
//   rx_valid     in   one-cycle pulse, rx_byte holds a complete byte
//   rx_byte      in   received byte
//   tx_byte      out  byte to shift out on the next transfer
//   tx_load      out  one-cycle pulse when tx_byte takes a new value
//   reg_wr_en    out  one-cycle register write strobe
//   reg_addr     out  register address (read and write path)
//   reg_wdata    out  register write data
//   reg_rdata    in   combinational read data for reg_addr
//   busy         out  high whenever the sequencer is not IDLE
//   err_count    out  number of malformed commands, saturates at 255
// -----------------------------------------------------------------------------
module spi_cmd_sequencer #(
  parameter  int NUM_REGS = 8,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_active,
  input  logic          rx_valid,
  input  logic [7:0]    rx_byte,
  output logic [7:0]    tx_byte,
  output logic          tx_load,
  output logic          reg_wr_en,
  output logic [AW-1:0] reg_addr,
  output logic [7:0]    reg_wdata,
  input  logic [7:0]    reg_rdata,
  output logic          busy,
  output logic [7:0]    err_count
);

`ifdef SPI_SEQ_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_WRITE   = 3'd2,
    S_READ    = 3'd3,
    S_DISCARD = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_tx_load;
  logic            r_wr_en;
  logic [AW-1:0]   r_addr;
  logic [7:0]      r_wdata;
  logic [7:0]      r_err;
  logic            w_rsvd;
  logic            w_wr_accept;

  // Any set bit between bit6 and bit AW marks a malformed command.
  assign w_rsvd = |(rx_byte[6:0] >> AW);

  // A data byte arriving while the previous write strobe is still high is
  // dropped so the strobe can never stay high for two cycles in a row.
  assign w_wr_accept = rx_valid && !r_wr_en;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic. Losing frame_active wins over everything, which also
  // drops an rx_valid that lands on the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (frame_active) w_next = S_CMD;
      end
      S_CMD: begin
        if (!frame_active)     w_next = S_IDLE;
        else if (rx_valid) begin
          if (w_rsvd)          w_next = S_DISCARD;
          else if (rx_byte[7]) w_next = S_WRITE;
          else                 w_next = S_READ;
        end
      end
      S_WRITE: begin
        if (!frame_active)                  w_next = S_IDLE;
        else if (w_wr_accept && !BURST_EN)  w_next = S_DISCARD;
      end
      S_READ: begin
        if (!frame_active)               w_next = S_IDLE;
        else if (rx_valid && !BURST_EN)  w_next = S_DISCARD;
      end
      S_DISCARD: begin
        if (!frame_active) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic. In READ the transmit byte follows the register file
  // directly, so it is valid in the same cycle the new address is.
  always_comb begin
    busy    = (r_state != S_IDLE);
    tx_byte = 8'h00;
    case (r_state)
      S_READ:    tx_byte = reg_rdata;
      S_DISCARD: tx_byte = 8'hFF;
      default:   tx_byte = 8'h00;
    endcase
  end

  // Datapath: address, write strobe/data, tx_load pulse, error counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_load <= 1'b0;
      r_wr_en   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= 8'h00;
      r_err     <= 8'h00;
    end else begin
      r_tx_load <= 1'b0;
      r_wr_en   <= 1'b0;
      if (r_state != S_IDLE && !frame_active) begin
        // Frame end: tx_byte returns to 8'h00 with a load pulse.
        r_tx_load <= 1'b1;
      end else begin
        case (r_state)
          S_CMD: begin
            if (rx_valid) begin
              if (w_rsvd) begin
                r_tx_load <= 1'b1;
                if (r_err != 8'hFF) r_err <= r_err + 8'd1;
              end else begin
                r_addr <= rx_byte[AW-1:0];
                if (!rx_byte[7]) r_tx_load <= 1'b1;
              end
            end
          end
          S_WRITE: begin
            // Advance only after the strobe cycle so the write uses the
            // address that was current when the byte arrived.
            if (r_wr_en && BURST_EN) r_addr <= r_addr + 1'b1;
            if (w_wr_accept) begin
              r_wr_en <= 1'b1;
              r_wdata <= rx_byte;
              if (!BURST_EN) r_tx_load <= 1'b1;
            end
          end
          S_READ: begin
            if (rx_valid) begin
              if (BURST_EN) r_addr <= r_addr + 1'b1;
              r_tx_load <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign tx_load   = r_tx_load;
  assign reg_wr_en = r_wr_en;
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign err_count = r_err;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_sequencer
//
// Self-checking bench. The bench owns the register file the DUT accesses.
// Every frame is first run through a transaction-level model that pushes the
// expected register writes and tx_load values onto a queue; a monitor pops
// and compares them as the DUT produces them. A table of frames covers the
// normal traffic, hand-written sequences cover frame abort, reset during a
// read and error-counter saturation.
// -----------------------------------------------------------------------------
module tb_spi_cmd_sequencer;
  localparam int NUM_REGS = 8;
  localparam int AW       = 3;
`ifdef SPI_SEQ_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_active;
  logic          rx_valid;
  logic [7:0]    rx_byte;
  logic [7:0]    tx_byte;
  logic          tx_load;
  logic          reg_wr_en;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata;
  logic [7:0]    reg_rdata;
  logic          busy;
  logic [7:0]    err_count;

  logic [7:0] mem [NUM_REGS];   // register file seen by the DUT
  logic [7:0] mdl [NUM_REGS];   // model's copy of the register file

  typedef struct {
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } ev_t;
  ev_t exp_q[$];
  ev_t mon_e;

  typedef struct {
    logic [7:0] b [4];
    int         n;
    int         exp_err;
  } vec_t;
  vec_t tbl [10];

  int errors = 0;
  int checks = 0;
  int m_err  = 0;
  logic prev_wr = 1'b0;

  spi_cmd_sequencer #(.NUM_REGS(NUM_REGS)) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_active (frame_active),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .tx_byte      (tx_byte),
    .tx_load      (tx_load),
    .reg_wr_en    (reg_wr_en),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_rdata    (reg_rdata),
    .busy         (busy),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  assign reg_rdata = mem[reg_addr];
  always @(posedge clk) if (reg_wr_en) mem[reg_addr] <= reg_wdata;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit w, input logic [AW-1:0] a, input logic [7:0] d);
    ev_t e;
    e.is_wr = w;
    e.addr  = a;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (reg_wr_en) begin
        chk("wr_back_to_back", int'(prev_wr), 0);
        chk("wr_while_idle", int'(busy), 1);
        if (exp_q.size() == 0 || !exp_q[0].is_wr) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr=%0d data=%02h, expected none", reg_addr, reg_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", int'(reg_addr), int'(mon_e.addr));
          chk("wr_data", int'(reg_wdata), int'(mon_e.data));
        end
      end
      if (tx_load) begin
        if (exp_q.size() == 0 || exp_q[0].is_wr) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx_load: got tx_byte=%02h, expected none", tx_byte);
        end else begin
          mon_e = exp_q.pop_front();
          chk("tx_byte", int'(tx_byte), int'(mon_e.data));
        end
      end
    end
    prev_wr = reg_wr_en && !rst;
  end

  // Transaction model of one complete frame.
  task automatic model_frame(input logic [7:0] b [4], input int n);
    logic [7:0]    c;
    logic [AW-1:0] a;
    c = b[0];
    a = c[AW-1:0];
    if ((c[6:0] >> AW) != 7'd0) begin
      push(1'b0, '0, 8'hFF);
      if (m_err < 255) m_err++;
    end else if (c[7]) begin
      for (int i = 1; i < n; i++) begin
        push(1'b1, a, b[i]);
        mdl[a] = b[i];
        if (BURST) a = a + 1'b1;
        else begin
          push(1'b0, '0, 8'hFF);
          break;
        end
      end
    end else begin
      push(1'b0, '0, mdl[a]);
      for (int i = 1; i < n; i++) begin
        if (BURST) begin
          a = a + 1'b1;
          push(1'b0, '0, mdl[a]);
        end else begin
          push(1'b0, '0, 8'hFF);
          break;
        end
      end
    end
    push(1'b0, '0, 8'h00);
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      step();
      k++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected events never seen, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_frame(input logic [7:0] b [4], input int n);
    model_frame(b, n);
    frame_active = 1'b1;
    repeat (2) step();
    for (int i = 0; i < n; i++) begin
      rx_byte  = b[i];
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
      repeat (4) step();
    end
    frame_active = 1'b0;
    repeat (3) step();
    wait_drain("frame_drain");
    chk("err_count", int'(err_count), m_err);
    chk("busy_after_frame", int'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] fb [4];

    tbl[0] = '{'{8'h82, 8'hA5, 8'h00, 8'h00}, 2, 0};
    tbl[1] = '{'{8'h06, 8'h00, 8'h00, 8'h00}, 4, 0};
    tbl[2] = '{'{8'h48, 8'h55, 8'h00, 8'h00}, 2, 1};
    tbl[3] = '{'{8'h83, 8'h01, 8'h02, 8'h00}, 3, 1};
    tbl[4] = '{'{8'h07, 8'h00, 8'h00, 8'h00}, 3, 1};
    tbl[5] = '{'{8'h81, 8'h3C, 8'h00, 8'h00}, 2, 1};
    tbl[6] = '{'{8'hF0, 8'h00, 8'h00, 8'h00}, 1, 2};
    tbl[7] = '{'{8'h01, 8'h00, 8'h00, 8'h00}, 1, 2};
    tbl[8] = '{'{8'h87, 8'hAA, 8'hBB, 8'h00}, 3, 2};
    tbl[9] = '{'{8'h00, 8'h00, 8'h00, 8'h00}, 2, 2};

    for (int i = 0; i < NUM_REGS; i++) mem[i] = 8'h40 + 8'(i);
    mem[6] = 8'h11;
    mem[7] = 8'h22;
    mem[0] = 8'h33;
    for (int i = 0; i < NUM_REGS; i++) mdl[i] = mem[i];

    rst = 1'b1;
    frame_active = 1'b0;
    rx_valid = 1'b0;
    rx_byte = 8'h00;
    #12;
    chk("reset_tx_byte", int'(tx_byte), 8'h00);
    chk("reset_tx_load", int'(tx_load), 0);
    chk("reset_wr_en", int'(reg_wr_en), 0);
    chk("reset_addr", int'(reg_addr), 0);
    chk("reset_wdata", int'(reg_wdata), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_err", int'(err_count), 0);
    step();
    rst = 1'b0;
    repeat (2) step();
    chk("idle_busy", int'(busy), 0);

    // Table-driven frames
    for (int i = 0; i < 10; i++) begin
      run_frame(tbl[i].b, tbl[i].n);
      chk("tbl_err_count", int'(err_count), tbl[i].exp_err);
      $display("vector %0d: cmd=%02h len=%0d err_count=%0d", i, tbl[i].b[0], tbl[i].n, err_count);
    end

    // Frame drops on the same cycle as a data byte: byte is lost.
    push(1'b0, '0, 8'h00);
    frame_active = 1'b1;
    repeat (2) step();
    rx_byte = 8'h82;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    repeat (3) step();
    rx_byte = 8'h77;
    rx_valid = 1'b1;
    frame_active = 1'b0;
    step();
    rx_valid = 1'b0;
    chk("drop_busy_next_cycle", int'(busy), 0);
    repeat (3) step();
    wait_drain("drop_drain");
    chk("drop_err_count", int'(err_count), m_err);
    $display("abort sequence: busy=%0d err_count=%0d", busy, err_count);

    // Reset in the middle of a read frame.
    push(1'b0, '0, mdl[6]);
    frame_active = 1'b1;
    repeat (2) step();
    rx_byte = 8'h06;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    step();
    chk("pre_reset_busy", int'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_tx_byte", int'(tx_byte), 8'h00);
    chk("rst_tx_load", int'(tx_load), 0);
    chk("rst_wr_en", int'(reg_wr_en), 0);
    chk("rst_addr", int'(reg_addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err_count), 0);
    exp_q.delete();
    m_err = 0;
    frame_active = 1'b0;
    step();
    rst = 1'b0;
    step();
    $display("reset sequence: busy=%0d err_count=%0d", busy, err_count);
    fb = '{8'h81, 8'h3C, 8'h00, 8'h00};
    run_frame(fb, 2);
    chk("post_reset_mem1", int'(mem[1]), 8'h3C);
    fb = '{8'h01, 8'h00, 8'h00, 8'h00};
    run_frame(fb, 1);

    // Error counter saturation.
    fb = '{8'h48, 8'h55, 8'h00, 8'h00};
    for (int i = 0; i < 256; i++) run_frame(fb, 2);
    chk("err_saturated", int'(err_count), 255);
    run_frame(fb, 2);
    chk("err_held", int'(err_count), 255);
    $display("saturation sequence: err_count=%0d", err_count);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
